// File: rtl/rv_wb_pkg.sv
// ---------------------------------------------------------------------------
// rv_wb_pkg
// Shared definitions for the register write-back stage:
//   - wb_state_t : write-back FSM states (IDLE, COMMIT)
//   - F3_*       : RV32 load funct3 encodings accepted by the stage
//   - is_legal_load() : true for the five supported load types
// ---------------------------------------------------------------------------
package rv_wb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return (funct3 == F3_LB)  || (funct3 == F3_LH)  || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage : rv_wb_pkg

// File: rtl/reg_writeback_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_if
// Bundles the two result sources (ALU, load unit) and the register-file
// write-back outputs of the write-back stage.
//   ALU source   : alu_valid, alu_ready, alu_rd, alu_value
//   Load source  : ld_valid, ld_ready, ld_rd, ld_funct3, ld_addr_lo, ld_data
//   Write-back   : wr_en, write_register, write_value
//   Hazard/status: pend_valid, pend_rd, ld_err
// Modports:
//   slave  - the write-back stage (consumes sources, drives write-back)
//   master - the pipeline around it (offers results, observes write-back)
// ---------------------------------------------------------------------------
interface reg_writeback_if #(
    parameter int XLEN = 32,
    parameter int NREG = 16
);
    localparam int IDX_W = $clog2(NREG);

    logic             alu_valid;
    logic             alu_ready;
    logic [IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]  alu_value;

    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_rd;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_addr_lo;
    logic [XLEN-1:0]  ld_data;

    logic             wr_en;
    logic [IDX_W-1:0] write_register;
    logic [XLEN-1:0]  write_value;

    logic             pend_valid;
    logic [IDX_W-1:0] pend_rd;
    logic             ld_err;

    modport slave (
        input  alu_valid, alu_rd, alu_value,
        input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
        output alu_ready, ld_ready,
        output wr_en, write_register, write_value,
        output pend_valid, pend_rd, ld_err
    );

    modport master (
        output alu_valid, alu_rd, alu_value,
        output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
        input  alu_ready, ld_ready,
        input  wr_en, write_register, write_value,
        input  pend_valid, pend_rd, ld_err
    );

endinterface : reg_writeback_if

// File: rtl/load_format.sv
// ---------------------------------------------------------------------------
// load_format
// Combinational load-data extraction. Picks the addressed byte/halfword out
// of an aligned memory word and sign- or zero-extends it to XLEN.
// Ports:
//   funct3  [2:0]      load type (LB, LH, LW, LBU, LHU)
//   addr_lo [1:0]      byte offset within the word
//   data    [XLEN-1:0] raw aligned memory word
//   value   [XLEN-1:0] formatted load result (0 when illegal)
//   illegal            funct3 is not one of the supported load types
// ---------------------------------------------------------------------------
module load_format
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] value,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane from the full offset; halfword lane from offset bit 1 only,
    // so a misaligned halfword offset silently rounds down.
    assign byte_sel = data[{addr_lo, 3'b000} +: 8];
    assign half_sel = data[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        value   = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   value = data;
            default: illegal = 1'b1;
        endcase
    end

endmodule : load_format

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
// Write-back stage arbitrating between an ALU result and a load result.
// A source is accepted in IDLE (load has priority), captured into
// registers, and committed to the register file in the following COMMIT
// cycle. Writes to x0 and loads with an unsupported funct3 are dropped;
// the latter raise ld_err for their COMMIT cycle.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - reg_writeback_if.slave: ALU/load handshakes, register-file
//          write (wr_en, write_register, write_value), pending-write
//          status (pend_valid, pend_rd) and ld_err
// Parameters:
//   XLEN - datapath width
//   NREG - register count (index width is $clog2(NREG))
// ---------------------------------------------------------------------------
module reg_writeback
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    reg_writeback_if.slave  bus
);

    localparam int IDX_W = $clog2(NREG);

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        logic [XLEN-1:0]  value;
        logic             illegal;
    } capture_t;

    wb_state_t        state_q, state_d;
    logic [IDX_W-1:0] rd_q;
    logic [XLEN-1:0]  value_q;
    logic             illegal_q;

    logic             cap_en;
    capture_t         cap;

    logic [XLEN-1:0]  ld_value;
    logic             ld_illegal;
    logic             in_commit;

    load_format #(
        .XLEN (XLEN)
    ) u_load_format (
        .funct3  (bus.ld_funct3),
        .addr_lo (bus.ld_addr_lo),
        .data    (bus.ld_data),
        .value   (ld_value),
        .illegal (ld_illegal)
    );

    // Next-state and accept logic. Readies are purely combinational and
    // held low during reset so no source is consumed while rst is high.
    always_comb begin
        state_d       = state_q;
        bus.ld_ready  = 1'b0;
        bus.alu_ready = 1'b0;
        cap_en        = 1'b0;
        cap.rd        = bus.alu_rd;
        cap.value     = bus.alu_value;
        cap.illegal   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (bus.ld_valid) begin
                        bus.ld_ready = 1'b1;
                        cap_en       = 1'b1;
                        cap.rd       = bus.ld_rd;
                        cap.value    = ld_value;
                        cap.illegal  = ld_illegal;
                        state_d      = COMMIT;
                    end else if (bus.alu_valid) begin
                        bus.alu_ready = 1'b1;
                        cap_en        = 1'b1;
                        state_d       = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            // NOTE: the captured write data is reset as well, because the
            // write-back outputs must read as zero after reset rather than
            // holding whatever the last capture left behind.
            rd_q      <= '0;
            value_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                rd_q      <= cap.rd;
                value_q   <= cap.value;
                illegal_q <= cap.illegal;
            end
        end
    end

    assign in_commit = (state_q == COMMIT);

    // The strobe exists only for the single COMMIT cycle; x0 targets and
    // illegal loads still occupy that cycle (pend_valid) but never write.
    assign bus.wr_en          = in_commit && (rd_q != '0) && !illegal_q;
    assign bus.ld_err         = in_commit && illegal_q;
    assign bus.pend_valid     = in_commit;
    assign bus.pend_rd        = rd_q;
    assign bus.write_register = rd_q;
    assign bus.write_value    = value_q;

endmodule : reg_writeback

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
// Self-checking bench for reg_writeback. A transaction-level model predicts
// the expected outputs every cycle; directed sequences add literal
// expectations for the documented example transactions.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_writeback_if #(.XLEN(32), .NREG(16)) bus_if ();

    reg_writeback #(
        .XLEN (32),
        .NREG (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatting written from the ISA definition.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] d, output bit ill);
        int unsigned b;
        int unsigned h;
        ill = 1'b0;
        b = (d >> (8 * int'(lo))) & 32'hFF;
        h = (d >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128)   ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b010:  return d;
            3'b100:  return b;
            3'b101:  return h;
            default: begin ill = 1'b1; return 32'h0; end
        endcase
    endfunction

    // Transaction model: one pending write at a time, lasting one cycle.
    bit          m_busy = 1'b0;
    logic [3:0]  m_rd   = 4'h0;
    logic [31:0] m_val  = 32'h0;
    bit          m_val_known = 1'b1;
    bit          m_ill  = 1'b0;

    always @(posedge clk) begin
        bit ill;
        if (rst) begin
            m_busy = 1'b0; m_rd = 4'h0; m_val = 32'h0; m_val_known = 1'b1; m_ill = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (bus_if.ld_valid) begin
            m_busy = 1'b1;
            m_rd   = bus_if.ld_rd;
            m_val  = ref_load(bus_if.ld_funct3, bus_if.ld_addr_lo, bus_if.ld_data, ill);
            m_ill  = ill;
            m_val_known = !ill;
        end else if (bus_if.alu_valid) begin
            m_busy = 1'b1;
            m_rd   = bus_if.alu_rd;
            m_val  = bus_if.alu_value;
            m_ill  = 1'b0;
            m_val_known = 1'b1;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ld_ready",  bus_if.ld_ready,  !rst && !m_busy && bus_if.ld_valid);
            check("m_alu_ready", bus_if.alu_ready, !rst && !m_busy && !bus_if.ld_valid && bus_if.alu_valid);
            check("m_wr_en",     bus_if.wr_en,     m_busy && (m_rd != 4'h0) && !m_ill);
            check("m_pend_valid", bus_if.pend_valid, m_busy);
            check("m_ld_err",    bus_if.ld_err,    m_busy && m_ill);
            check("m_write_register", bus_if.write_register, m_rd);
            check("m_pend_rd",   bus_if.pend_rd,   m_rd);
            if (m_val_known) check("m_write_value", bus_if.write_value, m_val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [3:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] d);
        bus_if.ld_valid   = 1'b1;
        bus_if.ld_rd      = rd;
        bus_if.ld_funct3  = f3;
        bus_if.ld_addr_lo = lo;
        bus_if.ld_data    = d;
    endtask

    task automatic set_alu(input logic [3:0] rd, input logic [31:0] v);
        bus_if.alu_valid = 1'b1;
        bus_if.alu_rd    = rd;
        bus_if.alu_value = v;
    endtask

    task automatic clr();
        bus_if.ld_valid  = 1'b0;
        bus_if.alu_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] data;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[7] = '{
        '{3'b100, 2'd1, 32'h12803456, 32'h00000034},
        '{3'b000, 2'd3, 32'h92803456, 32'hFFFFFF92},
        '{3'b100, 2'd0, 32'h000000F0, 32'h000000F0},
        '{3'b001, 2'd0, 32'h12348765, 32'hFFFF8765},
        '{3'b001, 2'd3, 32'h7FFF0000, 32'h00007FFF},
        '{3'b010, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF},
        '{3'b101, 2'd1, 32'h0000FFFE, 32'h0000FFFE}
    };

    initial begin
        int pulses;
        bus_if.alu_valid = 1'b0; bus_if.alu_rd = '0; bus_if.alu_value = '0;
        bus_if.ld_valid = 1'b0;  bus_if.ld_rd = '0;  bus_if.ld_funct3 = '0;
        bus_if.ld_addr_lo = '0;  bus_if.ld_data = '0;

        // Reset
        rst = 1'b1;
        tick(); tick();
        check("rst_wr_en", bus_if.wr_en, 1'b0);
        check("rst_write_value", bus_if.write_value, 32'h0);
        check("rst_pend_valid", bus_if.pend_valid, 1'b0);
        rst = 1'b0;
        tick();

        // LB sign extension of byte 2
        set_ld(4'd5, 3'b000, 2'd2, 32'h12803456);
        tick(); clr();
        check("lb_wr_en", bus_if.wr_en, 1'b1);
        check("lb_reg", bus_if.write_register, 32'd5);
        check("lb_val", bus_if.write_value, 32'hFFFFFF80);
        tick();
        check("lb_wr_en_low", bus_if.wr_en, 1'b0);

        // LHU upper halfword
        set_ld(4'd3, 3'b101, 2'd2, 32'hBEEF0000);
        tick(); clr();
        check("lhu_wr_en", bus_if.wr_en, 1'b1);
        check("lhu_val", bus_if.write_value, 32'h0000BEEF);
        tick();
        check("lhu_one_cycle", bus_if.wr_en, 1'b0);
        check("lhu_val_hold", bus_if.write_value, 32'h0000BEEF);

        // Load and ALU together: load first, ALU two cycles later
        set_ld(4'd1, 3'b010, 2'd0, 32'hCAFEF00D);
        set_alu(4'd2, 32'h000000A5);
        #1;
        check("both_ld_ready", bus_if.ld_ready, 1'b1);
        check("both_alu_wait", bus_if.alu_ready, 1'b0);
        tick();
        bus_if.ld_valid = 1'b0;
        check("both_ld_commit", bus_if.wr_en, 1'b1);
        check("both_ld_reg", bus_if.write_register, 32'd1);
        tick();
        check("both_gap", bus_if.wr_en, 1'b0);
        check("both_alu_ready", bus_if.alu_ready, 1'b1);
        tick(); clr();
        check("both_alu_commit", bus_if.wr_en, 1'b1);
        check("both_alu_reg", bus_if.write_register, 32'd2);
        check("both_alu_val", bus_if.write_value, 32'h000000A5);
        tick();

        // ALU write to x0 is dropped
        set_alu(4'd0, 32'h0000FFFF);
        #1;
        check("x0_alu_ready", bus_if.alu_ready, 1'b1);
        tick(); clr();
        check("x0_pend_valid", bus_if.pend_valid, 1'b1);
        check("x0_wr_en", bus_if.wr_en, 1'b0);
        tick();
        check("x0_pend_done", bus_if.pend_valid, 1'b0);

        // Illegal funct3
        set_ld(4'd9, 3'b011, 2'd0, 32'h55555555);
        tick(); clr();
        check("ill_ld_err", bus_if.ld_err, 1'b1);
        check("ill_wr_en", bus_if.wr_en, 1'b0);
        tick();
        check("ill_ld_err_off", bus_if.ld_err, 1'b0);
        set_alu(4'd4, 32'h00000077);
        #1;
        check("ill_back_idle", bus_if.alu_ready, 1'b1);
        tick(); clr();
        check("ill_next_write", bus_if.wr_en, 1'b1);
        tick();

        // Reset asserted in COMMIT aborts further activity
        set_alu(4'd7, 32'h00001234);
        tick();
        check("rc_commit", bus_if.wr_en, 1'b1);
        rst = 1'b1;
        #1;
        check("rc_no_ready", bus_if.alu_ready, 1'b0);
        tick();
        check("rc_wr_en", bus_if.wr_en, 1'b0);
        check("rc_reg", bus_if.write_register, 32'd0);
        check("rc_val", bus_if.write_value, 32'h0);
        check("rc_pend_valid", bus_if.pend_valid, 1'b0);
        check("rc_pend_rd", bus_if.pend_rd, 32'd0);
        check("rc_ld_err", bus_if.ld_err, 1'b0);
        tick();
        rst = 1'b0; clr();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.wr_en) pulses++;
        end
        check("rc_no_strobe", pulses, 32'd0);

        // Load formatting table
        for (int i = 0; i < 7; i++) begin
            set_ld(4'(i + 8), vecs[i].f3, vecs[i].lo, vecs[i].data);
            tick(); clr();
            check($sformatf("tbl%0d_val", i), bus_if.write_value, vecs[i].exp);
            tick();
        end

        // Continuous load offers: one write every two cycles
        set_ld(4'd6, 3'b010, 2'd0, 32'h11111111);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.wr_en) pulses++;
        end
        clr();
        check("tput_pulses", pulses, 32'd3);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_writeback

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameters, one per line (name, default, meaning): XLEN, 32, datapath width; NREG, 16, register count (RV32E, 4-bit index).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_ready  output  1  ALU result accepted this cycle.
REQ-006 alu_rd  input  4  ALU destination index.
REQ-007 alu_value  input  XLEN  ALU result.
REQ-008 ld_valid  input  1  load data offered.
REQ-009 ld_ready  output  1  load data accepted this cycle.
REQ-010 ld_rd  input  4  load destination index.
REQ-011 ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 ld_addr_lo  input  2  byte offset of the load address.
REQ-013 ld_data  input  XLEN  raw aligned memory word.
REQ-014 wr_en  output  1  register-file write strobe.
REQ-015 write_register  output  4  register-file write index.
REQ-016 write_value  output  XLEN  register-file write data.
REQ-017 pend_valid  output  1  a captured write is not yet committed.
REQ-018 pend_rd  output  4  destination of the pending write, for hazard checks.
REQ-019 ld_err  output  1  one-cycle pulse on an accepted load with illegal funct3.

Function
REQ-020 States: IDLE and COMMIT only.
REQ-021 IDLE, ld_valid=1: ld_ready=1, load captured, next state COMMIT.
REQ-022 IDLE, ld_valid=0, alu_valid=1: alu_ready=1, ALU result captured, next state COMMIT.
REQ-023 Both valid in IDLE: the load wins; ALU waits with alu_ready=0.
REQ-024 A ready is asserted only in IDLE, only for the selected source, and only combinationally in the accept cycle.
REQ-025 COMMIT: both readies 0; wr_en=1 for exactly this cycle unless suppressed; next state always IDLE.
REQ-026 A write SHALL be suppressed (wr_en=0 in COMMIT) when the captured rd is 0.
REQ-027 A load with an illegal funct3 SHALL be suppressed and SHALL pulse ld_err in its COMMIT cycle.
REQ-028 write_register and write_value are registered, load on capture only, and stay stable through COMMIT and afterwards until the next capture.
REQ-029 wr_en is therefore low for at least one cycle between consecutive writes; maximum throughput is one write per 2 cycles.
REQ-030 Latency: source accept at edge N gives wr_en high in cycle N+1.
REQ-031 LB/LBU select byte ld_addr_lo from ld_data, sign- or zero-extended to XLEN.
REQ-032 LH/LHU select halfword ld_addr_lo[1], sign- or zero-extended; ld_addr_lo[0] is ignored.
REQ-033 LW passes ld_data unchanged; ld_addr_lo is ignored.
REQ-034 pend_valid=1 in COMMIT, including suppressed cycles; pend_rd equals the captured rd.

Reset
REQ-035 While rst=1 at a clock edge: state IDLE; wr_en, pend_valid, ld_err = 0; write_register = 0; write_value = 0; pend_rd = 0.
REQ-036 While rst=1 both readies are 0 and no source is accepted.
REQ-037 Reset asserted during COMMIT aborts the write: wr_en is 0 from the next cycle.

Structure
REQ-038 Shared package rv_wb_pkg holds the state enum (IDLE, COMMIT) and the five funct3 load-type constants.
REQ-039 Load extraction is one combinational sub-module, load_format: inputs funct3, addr_lo, data; outputs value and illegal.
REQ-040 Every register lives in reg_writeback.

Verification
REQ-041 Load LB: ld_rd=5, funct3=000, addr_lo=2, ld_data=0x12_80_34_56 -> one cycle later wr_en=1, write_register=5, write_value=0xFFFFFF80.
REQ-042 Load LHU: ld_rd=3, addr_lo=2, ld_data=0xBEEF0000 -> write_value=0x0000BEEF, wr_en high for one cycle only.
REQ-043 ALU and load both valid in the same cycle: load (rd=1) commits first; ALU (rd=2, 0xA5) is accepted 2 cycles later and commits in the next cycle; wr_en has a low gap between the two.
REQ-044 ALU write with rd=0, value 0xFFFF -> alu_ready=1, pend_valid=1 for one cycle, wr_en stays 0.
REQ-045 Load with funct3=011 -> ld_err pulses once, wr_en stays 0, FSM returns to IDLE.
REQ-046 rst=1 asserted in a COMMIT cycle -> next cycle all outputs are 0 and no further strobe occurs.
